// File: rtl/unsharp_mask_hir_if.sv
// Memory-port bundle for the unsharp-mask accelerator: one read port each for
// the image and the two 3-tap kernels, one write port for the mask result.
// All ports talk to synchronous RAMs: a read request (rd_en with addr_data)
// issued in cycle n returns rd_data during cycle n+1; a write (wr_en with
// addr_data/wr_data) lands on the rising edge that ends the strobe cycle.
// addr_en always mirrors the port's rd_en/wr_en.
interface unsharp_mask_hir_if #(parameter int DW = 32);
    logic [9:0]    img_p0_addr_data;
    logic          img_p0_addr_en;
    logic          img_p0_rd_en;
    logic [DW-1:0] img_p0_rd_data;

    logic [2:0]    kernelX_p0_addr_data;
    logic          kernelX_p0_addr_en;
    logic          kernelX_p0_rd_en;
    logic [DW-1:0] kernelX_p0_rd_data;

    logic [2:0]    kernelY_p0_addr_data;
    logic          kernelY_p0_addr_en;
    logic          kernelY_p0_rd_en;
    logic [DW-1:0] kernelY_p0_rd_data;

    logic [9:0]    mask_p0_addr_data;
    logic          mask_p0_addr_en;
    logic          mask_p0_wr_en;
    logic [DW-1:0] mask_p0_wr_data;

    // Accelerator side
    modport master (
        output img_p0_addr_data, img_p0_addr_en, img_p0_rd_en,
        input  img_p0_rd_data,
        output kernelX_p0_addr_data, kernelX_p0_addr_en, kernelX_p0_rd_en,
        input  kernelX_p0_rd_data,
        output kernelY_p0_addr_data, kernelY_p0_addr_en, kernelY_p0_rd_en,
        input  kernelY_p0_rd_data,
        output mask_p0_addr_data, mask_p0_addr_en, mask_p0_wr_en, mask_p0_wr_data
    );

    // Memory side
    modport slave (
        input  img_p0_addr_data, img_p0_addr_en, img_p0_rd_en,
        output img_p0_rd_data,
        input  kernelX_p0_addr_data, kernelX_p0_addr_en, kernelX_p0_rd_en,
        output kernelX_p0_rd_data,
        input  kernelY_p0_addr_data, kernelY_p0_addr_en, kernelY_p0_rd_en,
        output kernelY_p0_rd_data,
        input  mask_p0_addr_data, mask_p0_addr_en, mask_p0_wr_en, mask_p0_wr_data
    );
endinterface

// File: rtl/unsharp_mask_hir.sv
// Unsharp-mask detail generator for a 32x32 frame of signed pixels:
// mask = img - ((sum of ky[a]*kx[b]*img(i+a-1,j+b-1)) >>> SHIFT).
// Border pixels are written as 0. One start pulse runs one full frame:
// LOADK (7 cycles), then one cycle per border pixel and 11 per interior pixel
// (9 tap reads, 1 final capture, 1 write). state_dbg exposes the FSM state.
module unsharp_mask_hir #(
    parameter int SHIFT = 4,
    parameter int DW    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  t,
    unsharp_mask_hir_if.master    mem,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOADK = 2'd1,
        PIXEL = 2'd2
    } state_t;

    state_t state, state_n;

    logic [3:0]           cnt;          // cycle within LOADK or within a pixel
    logic [4:0]           row, col;     // current pixel (i, j)
    logic signed [DW-1:0] kx [3];
    logic signed [DW-1:0] ky [3];
    logic signed [63:0]   acc;          // wraps modulo 2^64
    logic signed [DW-1:0] centre;       // img(i,j), captured from the (1,1) tap

    // Last driven addresses, so idle address lines hold their value
    logic [9:0] img_addr_q, mask_addr_q;
    logic [2:0] kx_addr_q, ky_addr_q;

    logic                 border, last_pix, pix_done;
    logic                 kx_rd, ky_rd, img_rd, wr;
    logic [1:0]           req_a, req_b, cap_a, cap_b;
    logic [4:0]           tap_row, tap_col;
    logic signed [DW-1:0] pix, coef, blur, mask_val;
    logic [63:0]          prod;

    // Tap index n = 0..8 maps to (a, b) with a outer, b inner
    function automatic logic [3:0] tap_of(input logic [3:0] n);
        case (n)
            4'd0:    tap_of = {2'd0, 2'd0};
            4'd1:    tap_of = {2'd0, 2'd1};
            4'd2:    tap_of = {2'd0, 2'd2};
            4'd3:    tap_of = {2'd1, 2'd0};
            4'd4:    tap_of = {2'd1, 2'd1};
            4'd5:    tap_of = {2'd1, 2'd2};
            4'd6:    tap_of = {2'd2, 2'd0};
            4'd7:    tap_of = {2'd2, 2'd1};
            4'd8:    tap_of = {2'd2, 2'd2};
            default: tap_of = 4'd0;
        endcase
    endfunction

    // Pixel classification, tap selection and the multiply-accumulate terms
    always_comb begin
        border     = (row == 5'd0) || (row == 5'd31) || (col == 5'd0) || (col == 5'd31);
        last_pix   = (row == 5'd31) && (col == 5'd31);
        pix_done   = border || (cnt == 4'd10);
        {req_a, req_b} = tap_of(cnt);
        // data arriving this cycle belongs to the request of the previous cycle
        {cap_a, cap_b} = tap_of(cnt - 4'd1);
        tap_row    = row + {3'b000, req_a} - 5'd1;
        tap_col    = col + {3'b000, req_b} - 5'd1;
        pix        = mem.img_p0_rd_data;
        coef       = ky[cap_a] * kx[cap_b];
        prod       = {{(64-DW){coef[DW-1]}}, coef} * {{(64-DW){pix[DW-1]}}, pix};
        blur       = acc[SHIFT+DW-1:SHIFT];
        mask_val   = centre - blur;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // Next state and per-cycle memory strobes
    always_comb begin
        state_n = state;
        kx_rd   = 1'b0;
        ky_rd   = 1'b0;
        img_rd  = 1'b0;
        wr      = 1'b0;
        case (state)
            IDLE: begin
                if (t) state_n = LOADK;
            end
            LOADK: begin
                kx_rd = (cnt < 4'd3);
                ky_rd = (cnt >= 4'd3) && (cnt < 4'd6);
                if (cnt == 4'd6) state_n = PIXEL;
            end
            PIXEL: begin
                img_rd = !border && (cnt < 4'd9);
                wr     = pix_done;
                if (pix_done && last_pix) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Port drive: addresses follow the active request, else hold the last one
    always_comb begin
        mem.img_p0_rd_en         = img_rd;
        mem.img_p0_addr_en       = img_rd;
        mem.img_p0_addr_data     = img_rd ? {tap_row, tap_col} : img_addr_q;
        mem.kernelX_p0_rd_en     = kx_rd;
        mem.kernelX_p0_addr_en   = kx_rd;
        mem.kernelX_p0_addr_data = kx_rd ? cnt[2:0] : kx_addr_q;
        mem.kernelY_p0_rd_en     = ky_rd;
        mem.kernelY_p0_addr_en   = ky_rd;
        mem.kernelY_p0_addr_data = ky_rd ? (cnt[2:0] - 3'd3) : ky_addr_q;
        mem.mask_p0_wr_en        = wr;
        mem.mask_p0_addr_en      = wr;
        mem.mask_p0_addr_data    = wr ? {row, col} : mask_addr_q;
        mem.mask_p0_wr_data      = (wr && !border) ? mask_val : '0;
        state_dbg                = state;
    end

    // Counters, kernel capture, accumulator and address hold registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            row         <= '0;
            col         <= '0;
            acc         <= '0;
            centre      <= '0;
            img_addr_q  <= '0;
            mask_addr_q <= '0;
            kx_addr_q   <= '0;
            ky_addr_q   <= '0;
            for (int k = 0; k < 3; k++) begin
                kx[k] <= '0;
                ky[k] <= '0;
            end
        end else begin
            img_addr_q  <= mem.img_p0_addr_data;
            mask_addr_q <= mem.mask_p0_addr_data;
            kx_addr_q   <= mem.kernelX_p0_addr_data;
            ky_addr_q   <= mem.kernelY_p0_addr_data;
            case (state)
                IDLE: begin
                    if (t) begin
                        cnt <= '0;
                        row <= '0;
                        col <= '0;
                    end
                end
                LOADK: begin
                    cnt <= (cnt == 4'd6) ? 4'd0 : cnt + 4'd1;
                    case (cnt)
                        4'd1: kx[0] <= mem.kernelX_p0_rd_data;
                        4'd2: kx[1] <= mem.kernelX_p0_rd_data;
                        4'd3: kx[2] <= mem.kernelX_p0_rd_data;
                        4'd4: ky[0] <= mem.kernelY_p0_rd_data;
                        4'd5: ky[1] <= mem.kernelY_p0_rd_data;
                        4'd6: ky[2] <= mem.kernelY_p0_rd_data;
                        default: ;
                    endcase
                end
                PIXEL: begin
                    if (pix_done) begin
                        cnt <= '0;
                        col <= col + 5'd1;
                        if (col == 5'd31) row <= row + 5'd1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                    if (!border && (cnt >= 4'd1) && (cnt <= 4'd9)) begin
                        acc <= ((cnt == 4'd1) ? 64'sd0 : acc) + $signed(prod);
                        if (cnt == 4'd5) centre <= pix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_unsharp_mask_hir.sv
// Testbench for unsharp_mask_hir: synchronous RAM models, a frame-level
// reference model feeding an expected-write queue, and a negedge monitor that
// pops and compares every mask write and kernel read.
module tb_unsharp_mask_hir;
  localparam int SHIFT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic t = 1'b0;
  logic [1:0] state_dbg;

  unsharp_mask_hir_if bus();

  unsharp_mask_hir #(.SHIFT(SHIFT), .DW(32)) dut (
    .clk(clk),
    .rst(rst),
    .t(t),
    .mem(bus),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memories ----------------
  logic [31:0] img_mem [1024];
  logic [31:0] kx_mem [8];
  logic [31:0] ky_mem [8];
  logic [31:0] mask_mem [1024];

  always @(posedge clk) begin
    if (bus.img_p0_rd_en) bus.img_p0_rd_data <= img_mem[bus.img_p0_addr_data];
    if (bus.kernelX_p0_rd_en) bus.kernelX_p0_rd_data <= kx_mem[bus.kernelX_p0_addr_data];
    if (bus.kernelY_p0_rd_en) bus.kernelY_p0_rd_data <= ky_mem[bus.kernelY_p0_addr_data];
    if (bus.mask_p0_wr_en) mask_mem[bus.mask_p0_addr_data] <= bus.mask_p0_wr_data;
  end

  // ---------------- scoreboard state ----------------
  logic [41:0] exp_q[$];   // {addr, data} of expected mask writes, in order
  logic [11:0] kexp_q[$];  // {is_y, addr, rel_cycle} of expected kernel reads
  int checks = 0;
  int errors = 0;
  int t_cyc = 0;
  int wr_cnt = 0;
  int img_rd_cnt = 0;
  int first_img_rel = -1;
  int first_wr_rel = -1;
  int last_wr_rel = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event (t=%0t)", name, $time);
  endtask

  // ---------------- monitor ----------------
  int rel;
  logic [11:0] kexp;
  logic [41:0] wexp;
  always @(negedge clk) begin
    if (rst) begin
      rel = cyc - t_cyc;
      check("addr_en_tie",
            {60'd0, bus.img_p0_addr_en, bus.kernelX_p0_addr_en, bus.kernelY_p0_addr_en, bus.mask_p0_addr_en},
            {60'd0, bus.img_p0_rd_en, bus.kernelX_p0_rd_en, bus.kernelY_p0_rd_en, bus.mask_p0_wr_en});
      if (bus.kernelX_p0_rd_en) begin
        if (kexp_q.size() == 0) fail("kx_read_unexpected");
        else begin
          kexp = kexp_q.pop_front();
          check("kx_read", {52'd0, 1'b0, bus.kernelX_p0_addr_data, rel[7:0]}, {52'd0, kexp});
        end
      end
      if (bus.kernelY_p0_rd_en) begin
        if (kexp_q.size() == 0) fail("ky_read_unexpected");
        else begin
          kexp = kexp_q.pop_front();
          check("ky_read", {52'd0, 1'b1, bus.kernelY_p0_addr_data, rel[7:0]}, {52'd0, kexp});
        end
      end
      if (bus.img_p0_rd_en) begin
        img_rd_cnt++;
        if (first_img_rel < 0) first_img_rel = rel;
      end
      if (bus.mask_p0_wr_en) begin
        wr_cnt++;
        if (first_wr_rel < 0) first_wr_rel = rel;
        last_wr_rel = rel;
        if (exp_q.size() == 0) fail("mask_write_unexpected");
        else begin
          wexp = exp_q.pop_front();
          check("mask_write", {22'd0, bus.mask_p0_addr_data, bus.mask_p0_wr_data}, {22'd0, wexp});
        end
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic build_expected();
    logic signed [31:0] c, px, blur, centre_px, m;
    longint acc, sh;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 32; j++) begin
        if (i == 0 || j == 0 || i == 31 || j == 31) begin
          m = 32'sd0;
        end else begin
          acc = 0;
          for (int a = 0; a < 3; a++) begin
            for (int b = 0; b < 3; b++) begin
              c = $signed(ky_mem[a]) * $signed(kx_mem[b]);
              px = $signed(img_mem[(i + a - 1) * 32 + (j + b - 1)]);
              acc = acc + longint'(c) * longint'(px);
            end
          end
          sh = acc >>> SHIFT;
          blur = sh[31:0];
          centre_px = $signed(img_mem[i * 32 + j]);
          m = centre_px - blur;
        end
        exp_q.push_back({10'(i * 32 + j), m});
      end
    end
    for (int k = 0; k < 3; k++) kexp_q.push_back({1'b0, 3'(k), 8'(1 + k)});
    for (int k = 0; k < 3; k++) kexp_q.push_back({1'b1, 3'(k), 8'(4 + k)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_pass();
    build_expected();
    @(negedge clk);
    t_cyc = cyc;
    wr_cnt = 0;
    img_rd_cnt = 0;
    first_img_rel = -1;
    first_wr_rel = -1;
    last_wr_rel = -1;
    t = 1'b1;
    @(negedge clk);
    t = 1'b0;
  endtask

  task automatic wait_rel(input int n);
    while (cyc - t_cyc < n) @(negedge clk);
  endtask

  task automatic run_pass(input bit mid_t);
    start_pass();
    if (mid_t) begin
      wait_rel(3000);
      t = 1'b1;
      @(negedge clk);
      t = 1'b0;
    end
    wait_rel(10040);
    check("write_count", 64'(wr_cnt), 64'd1024);
    check("first_write_cycle", 64'(first_wr_rel), 64'd8);
    check("last_write_cycle", 64'(last_wr_rel), 64'd10031);
    check("first_img_read_cycle", 64'(first_img_rel), 64'd41);
    check("img_read_count", 64'(img_rd_cnt), 64'd8100);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("kernel_q_drained", 64'(kexp_q.size()), 64'd0);
    check("idle_after_pass", 64'(state_dbg), 64'd0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_rd_side"},
          {30'd0, bus.img_p0_addr_data, bus.img_p0_addr_en, bus.img_p0_rd_en,
           bus.kernelX_p0_addr_data, bus.kernelX_p0_addr_en, bus.kernelX_p0_rd_en,
           bus.kernelY_p0_addr_data, bus.kernelY_p0_addr_en, bus.kernelY_p0_rd_en, state_dbg},
          64'd0);
    check({name, "_wr_side"},
          {20'd0, bus.mask_p0_addr_data, bus.mask_p0_addr_en, bus.mask_p0_wr_en, bus.mask_p0_wr_data},
          64'd0);
  endtask

  task automatic set_kernels_121();
    for (int k = 0; k < 8; k++) begin
      kx_mem[k] = 32'd0;
      ky_mem[k] = 32'd0;
    end
    kx_mem[0] = 32'd1; kx_mem[1] = 32'd2; kx_mem[2] = 32'd1;
    ky_mem[0] = 32'd1; ky_mem[1] = 32'd2; ky_mem[2] = 32'd1;
  endtask

  task automatic fill_img(input logic [31:0] v);
    for (int k = 0; k < 1024; k++) img_mem[k] = v;
  endtask

  int rec_wr;

  // ---------------- main sequence ----------------
  initial begin
    set_kernels_121();
    fill_img(32'd0);

    // reset state
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("idle_after_reset");

    // flat image with a second start pulse mid-pass
    fill_img(32'd100);
    run_pass(1'b1);

    // impulse
    fill_img(32'd0);
    img_mem[5 * 32 + 5] = 32'd16;
    run_pass(1'b0);
    check("impulse_5_5", 64'(mask_mem[5 * 32 + 5]), 64'd12);
    check("impulse_5_4", 64'(mask_mem[5 * 32 + 4]), 64'hFFFF_FFFE);
    check("impulse_4_5", 64'(mask_mem[4 * 32 + 5]), 64'hFFFF_FFFE);
    check("impulse_4_4", 64'(mask_mem[4 * 32 + 4]), 64'hFFFF_FFFF);
    check("impulse_7_7", 64'(mask_mem[7 * 32 + 7]), 64'd0);

    // negative impulse
    fill_img(32'd0);
    img_mem[10 * 32 + 10] = 32'hFFFF_FFE0;
    run_pass(1'b0);
    check("neg_10_10", 64'(mask_mem[10 * 32 + 10]), 64'hFFFF_FFE8);
    check("neg_10_11", 64'(mask_mem[10 * 32 + 11]), 64'd4);

    // random image and kernels, reset mid-pass then a full rerun
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 8; k++) begin
        kx_mem[k] = (r == 0) ? 32'($urandom_range(0, 15)) - 32'd7 : $urandom;
        ky_mem[k] = (r == 0) ? 32'($urandom_range(0, 15)) - 32'd7 : $urandom;
      end
      for (int k = 0; k < 1024; k++) img_mem[k] = $urandom;

      if (r == 0) begin
        start_pass();
        wait_rel(500);
        #2 rst = 1'b0;
        #1 check_outputs_zero("mid_pass_reset");
        exp_q.delete();
        kexp_q.delete();
        rec_wr = wr_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check("no_write_after_reset", 64'(wr_cnt), 64'(rec_wr));
        check("idle_after_mid_reset", 64'(state_dbg), 64'd0);
      end
      run_pass(1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
